// File: rtl/sseg_pkg.sv
// Shared 7-segment definitions: character codes and active-low glyph patterns.
// Bit order of every SEG_* constant is {a,b,c,d,e,f,g,h}, h = decimal point (off here).
package sseg_pkg;

  typedef enum logic [4:0] {
    CH_0 = 5'd0, CH_1, CH_2, CH_3, CH_4, CH_5, CH_6, CH_7,
    CH_8, CH_9, CH_A, CH_B, CH_C, CH_D, CH_E, CH_F,
    CH_H, CH_K, CH_L, CH_P, CH_U, CH_BLANK, CH_UNKNOWN
  } char_t;

  localparam logic [7:0] SEG_0     = 8'h03;
  localparam logic [7:0] SEG_1     = 8'h9F;
  localparam logic [7:0] SEG_2     = 8'h25;
  localparam logic [7:0] SEG_3     = 8'h0D;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h49;
  localparam logic [7:0] SEG_6     = 8'h41;
  localparam logic [7:0] SEG_7     = 8'h1F;
  localparam logic [7:0] SEG_8     = 8'h01;
  localparam logic [7:0] SEG_9     = 8'h09;
  localparam logic [7:0] SEG_A     = 8'h11;
  localparam logic [7:0] SEG_B     = 8'hC1;
  localparam logic [7:0] SEG_C     = 8'h63;
  localparam logic [7:0] SEG_D     = 8'h85;
  localparam logic [7:0] SEG_E     = 8'h61;
  localparam logic [7:0] SEG_F     = 8'h71;
  localparam logic [7:0] SEG_H     = 8'h91;
  localparam logic [7:0] SEG_K     = 8'h51;
  localparam logic [7:0] SEG_L     = 8'hE3;
  localparam logic [7:0] SEG_P     = 8'h31;
  localparam logic [7:0] SEG_U     = 8'h83;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [19:0] BLANK_WORD = {4{5'(CH_BLANK)}};

endpackage

// File: rtl/sseg_glyph_decode.sv
// Combinational lookup of a 7-bit active-low segment pattern {a..g} to a char_t.
// Patterns outside the glyph table decode to CH_UNKNOWN.
module sseg_glyph_decode
  import sseg_pkg::*;
(
  input  logic [6:0] segs,
  output char_t      ch
);

  always_comb begin
    ch = CH_UNKNOWN;
    case (segs)
      SEG_0[7:1]:     ch = CH_0;
      SEG_1[7:1]:     ch = CH_1;
      SEG_2[7:1]:     ch = CH_2;
      SEG_3[7:1]:     ch = CH_3;
      SEG_4[7:1]:     ch = CH_4;
      SEG_5[7:1]:     ch = CH_5;
      SEG_6[7:1]:     ch = CH_6;
      SEG_7[7:1]:     ch = CH_7;
      SEG_8[7:1]:     ch = CH_8;
      SEG_9[7:1]:     ch = CH_9;
      SEG_A[7:1]:     ch = CH_A;
      SEG_B[7:1]:     ch = CH_B;
      SEG_C[7:1]:     ch = CH_C;
      SEG_D[7:1]:     ch = CH_D;
      SEG_E[7:1]:     ch = CH_E;
      SEG_F[7:1]:     ch = CH_F;
      SEG_H[7:1]:     ch = CH_H;
      SEG_K[7:1]:     ch = CH_K;
      SEG_L[7:1]:     ch = CH_L;
      SEG_P[7:1]:     ch = CH_P;
      SEG_U[7:1]:     ch = CH_U;
      SEG_BLANK[7:1]: ch = CH_BLANK;
      default:        ch = CH_UNKNOWN;
    endcase
  end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Decodes a scanned 4-digit 7-segment bus back into a 4-char word with a valid strobe.
// Optional SSEG_SCAN_DECODER_CHANGE_ONLY_EN: strobe only when the completed word differs.
module sseg_scan_decoder
  import sseg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 2**24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  abcdefgh,
  input  logic [3:0]  digit,
  output logic [19:0] word_chars,
  output logic [3:0]  word_dp,
  output logic        word_valid,
  output logic        bad_scan,
  output logic        stale
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);

  logic [11:0]   smp, smp_prev;
  logic [3:0]    smp_digit;
  logic [7:0]    smp_seg;
  logic [SW-1:0] stab_cnt;
  logic [TW-1:0] to_cnt;
  logic [3:0]    seen, seen_nxt, cap_mask;
  logic [19:0]   chars, chars_nxt;
  logic [3:0]    dp, dp_nxt;
  logic          one_hot, multi, stab_inc, cap, frame_full, word_changed, frame_done;
  char_t         dec_ch;

  assign smp_digit = smp[11:8];
  assign smp_seg   = smp[7:0];
  assign one_hot   = $onehot(~smp_digit);
  assign multi     = !one_hot && (smp_digit != 4'hF);
  assign stab_inc  = (smp == smp_prev) && one_hot;
  // Fires only on the transition into saturation, so a long dwell captures once.
  assign cap       = stab_inc && (stab_cnt == STAB_MAX - SW'(1));
  assign cap_mask  = cap ? ~smp_digit : 4'b0000;

  sseg_glyph_decode u_glyph (
    .segs (smp_seg[7:1]),
    .ch   (dec_ch)
  );

  always_comb begin
    chars_nxt = chars;
    dp_nxt    = dp;
    for (int i = 0; i < 4; i++) begin
      if (cap_mask[i]) begin
        chars_nxt[5*i +: 5] = dec_ch;
        dp_nxt[i]           = ~smp_seg[0];
      end
    end
  end

  assign seen_nxt   = seen | cap_mask;
  assign frame_full = (seen_nxt == 4'hF);

`ifdef SSEG_SCAN_DECODER_CHANGE_ONLY_EN
  assign word_changed = (chars_nxt != word_chars) || (dp_nxt != word_dp);
`else
  assign word_changed = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      smp      <= 12'hFFF;
      smp_prev <= 12'hFFF;
      stab_cnt <= '0;
      bad_scan <= 1'b0;
    end else begin
      smp      <= {digit, abcdefgh};
      smp_prev <= smp;
      if (!stab_inc)
        stab_cnt <= '0;
      else if (stab_cnt != STAB_MAX)
        stab_cnt <= stab_cnt + SW'(1);
      if (multi)
        bad_scan <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seen       <= 4'b0000;
      chars      <= BLANK_WORD;
      dp         <= 4'b0000;
      word_chars <= BLANK_WORD;
      word_dp    <= 4'b0000;
      word_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      chars      <= chars_nxt;
      dp         <= dp_nxt;
      word_valid <= 1'b0;
      frame_done <= 1'b0;
      if (frame_full) begin
        seen       <= 4'b0000;
        frame_done <= 1'b1;
        if (word_changed) begin
          word_chars <= chars_nxt;
          word_dp    <= dp_nxt;
          word_valid <= 1'b1;
        end
      end else begin
        seen <= seen_nxt;
      end
    end
  end

  // Cleared by every completed frame, including suppressed unchanged ones.
  always_ff @(posedge clk) begin
    if (reset)
      to_cnt <= '0;
    else if (frame_done)
      to_cnt <= '0;
    else if (to_cnt != TO_MAX)
      to_cnt <= to_cnt + TW'(1);
  end

  assign stale = (to_cnt >= TO_MAX);

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Scoreboard bench for sseg_scan_decoder: dwell-level reference model feeds an expected-word
// queue, an independent monitor pops and compares on every word_valid.
module tb_sseg_scan_decoder;

  localparam int S  = 4;
  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  abcdefgh;
  logic [3:0]  digit;
  logic [19:0] word_chars;
  logic [3:0]  word_dp;
  logic        word_valid, bad_scan, stale;

  sseg_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .abcdefgh   (abcdefgh),
    .digit      (digit),
    .word_chars (word_chars),
    .word_dp    (word_dp),
    .word_valid (word_valid),
    .bad_scan   (bad_scan),
    .stale      (stale)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int valid_cnt = 0;

  typedef struct packed {
    logic [19:0] chars;
    logic [3:0]  dp;
    int          at;
  } exp_t;
  exp_t exp_q[$];

  // Glyphs indexed by character code, dp off; independent of the design package.
  logic [7:0] glyph [22] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                             8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71,
                             8'h91, 8'h51, 8'hE3, 8'h31, 8'h83, 8'hFF};

  logic [4:0]  m_ch [4];
  logic [3:0]  m_dp;
  logic [3:0]  m_seen;
  logic [19:0] m_last_chars;
  logic [3:0]  m_last_dp;
  logic        m_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [7:0] seg);
    ref_decode = 5'd22;
    for (int i = 0; i < 22; i++)
      if (glyph[i][7:1] == seg[7:1]) ref_decode = 5'(i);
  endfunction

  function automatic logic [7:0] gseg(input int code, input logic lit_dp);
    logic [7:0] g;
    g = glyph[code];
    gseg = {g[7:1], ~lit_dp};
  endfunction

  // Reference: a dwell of len cycles on one digit captures iff len >= S+1.
  task automatic model_dwell(input logic [3:0] d, input logic [7:0] seg, input int len,
                             input int start);
    int zeros;
    logic [19:0] w;
    logic emit;
    exp_t e;
    zeros = 0;
    for (int i = 0; i < 4; i++) if (!d[i]) zeros++;
    if (zeros >= 2) begin
      m_bad = 1'b1;
    end else if (zeros == 1 && len >= S + 1) begin
      for (int i = 0; i < 4; i++) begin
        if (!d[i]) begin
          m_ch[i]   = ref_decode(seg);
          m_dp[i]   = ~seg[0];
          m_seen[i] = 1'b1;
        end
      end
      if (m_seen == 4'hF) begin
        m_seen = 4'h0;
        w = {m_ch[3], m_ch[2], m_ch[1], m_ch[0]};
        emit = 1'b1;
`ifdef SSEG_SCAN_DECODER_CHANGE_ONLY_EN
        emit = (w != m_last_chars) || (m_dp != m_last_dp);
`endif
        if (emit) begin
          e.chars = w;
          e.dp    = m_dp;
          e.at    = start + S + 2;
          exp_q.push_back(e);
          m_last_chars = w;
          m_last_dp    = m_dp;
        end
      end
    end
  endtask

  // Called at posedge+1; holds the bus value for len cycles.
  task automatic drive(input logic [3:0] d, input logic [7:0] seg, input int len);
    digit    = d;
    abcdefgh = seg;
    model_dwell(d, seg, len, cyc);
    repeat (len) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame(input logic [7:0] s3, input logic [7:0] s2, input logic [7:0] s1,
                       input logic [7:0] s0, input int len);
    drive(4'b0111, s3, len);
    drive(4'b1011, s2, len);
    drive(4'b1101, s1, len);
    drive(4'b1110, s0, len);
  endtask

  always @(negedge clk) begin
    if (!reset && word_valid) begin
      exp_t e;
      valid_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got word %0h dp %0h expected no strobe (cycle %0d)",
                 word_chars, word_dp, cyc);
      end else begin
        e = exp_q.pop_front();
        check("word_chars", 32'(word_chars), 32'(e.chars));
        check("word_dp", 32'(word_dp), 32'(e.dp));
        check("latency", cyc, e.at);
      end
    end
  end

  initial begin
    int vc;
    int wait_cnt;
    logic [3:0] d;
    logic [7:0] seg;
    int r;

    reset = 1'b1; digit = 4'hF; abcdefgh = 8'hFF;
    m_seen = 4'h0; m_dp = 4'h0; m_bad = 1'b0;
    for (int i = 0; i < 4; i++) m_ch[i] = 5'd21;
    m_last_chars = {4{5'd21}}; m_last_dp = 4'h0;

    // Reset holds with the bus toggling
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      digit = 4'($urandom); abcdefgh = 8'($urandom);
      @(negedge clk);
      check("rst_chars", 32'(word_chars), 32'({4{5'd21}}));
      check("rst_dp", 32'(word_dp), 32'h0);
      check("rst_valid", 32'(word_valid), 32'h0);
      check("rst_bad", 32'(bad_scan), 32'h0);
      check("rst_stale", 32'(stale), 32'h0);
    end
    @(posedge clk); #1;
    digit = 4'hF; abcdefgh = 8'hFF; reset = 1'b0;

    // Idle bus: stale rises exactly TIMEOUT cycles after reset
    repeat (TO - 1) @(posedge clk);
    #1;
    check("stale_before", 32'(stale), 32'h0);
    @(posedge clk); #1;
    check("stale_at", 32'(stale), 32'h1);

    // Directed A U C A frame, 8 cycles per digit
    drive(4'b0111, 8'h11, 8);
    drive(4'b1011, 8'h83, 8);
    drive(4'b1101, 8'h63, 8);
    check("stale_hold", 32'(stale), 32'h1);
    vc = valid_cnt;
    drive(4'b1110, 8'h11, 8);
    check("auca_strobes", valid_cnt - vc, 1);
    check("auca_chars", 32'(word_chars), 32'({5'd10, 5'd20, 5'd12, 5'd10}));
    check("auca_dp", 32'(word_dp), 32'h0);
    check("stale_cleared", 32'(stale), 32'h0);

    // Short dwell on the last digit: 3 cycles no capture, 5 cycles captures
    frame(gseg(1, 0), gseg(2, 1), gseg(3, 0), gseg(4, 0), 8);
    drive(4'b0111, gseg(5, 0), 8);
    drive(4'b1011, gseg(6, 0), 8);
    drive(4'b1101, gseg(7, 0), 8);
    vc = valid_cnt;
    drive(4'b1110, gseg(8, 0), 3);
    drive(4'hF, 8'hFF, 10);
    check("short_dwell", valid_cnt - vc, 0);
    drive(4'b1110, gseg(8, 0), S + 1);
    drive(4'hF, 8'hFF, 4);
    check("min_dwell", valid_cnt - vc, 1);

    // Blank glyph with dp, then an unmatched pattern
    frame(gseg(9, 0), gseg(0, 0), gseg(15, 0), 8'hFE, 8);
    drive(4'hF, 8'hFF, 2);
    check("blank_char", 32'(word_chars[4:0]), 32'd21);
    check("blank_dp", 32'(word_dp), 32'h1);
    frame(gseg(9, 0), gseg(0, 0), gseg(15, 0), 8'h54, 8);
    drive(4'hF, 8'hFF, 2);
    check("unknown_char", 32'(word_chars[4:0]), 32'd22);
    check("unknown_dp", 32'(word_dp), 32'h1);

    // Two digit enables low together
    check("bad_clear", 32'(bad_scan), 32'(m_bad));
    vc = valid_cnt;
    drive(4'b0011, gseg(2, 0), 10);
    check("bad_set", 32'(bad_scan), 32'h1);
    check("bad_nocap", valid_cnt - vc, 0);
    frame(gseg(11, 0), gseg(13, 0), gseg(14, 0), gseg(3, 0), 8);
    drive(4'hF, 8'hFF, 2);
    check("bad_frame", valid_cnt - vc, 1);
    check("bad_sticky", 32'(bad_scan), 32'h1);

    // Identical frames back to back
    vc = valid_cnt;
    frame(gseg(19, 0), gseg(18, 1), gseg(16, 0), gseg(17, 0), 8);
    frame(gseg(19, 0), gseg(18, 1), gseg(16, 0), gseg(17, 0), 8);
    drive(4'hF, 8'hFF, 2);
`ifdef SSEG_SCAN_DECODER_CHANGE_ONLY_EN
    check("repeat_frames", valid_cnt - vc, 1);
`else
    check("repeat_frames", valid_cnt - vc, 2);
`endif

    // Randomized dwells separated by short blanking gaps
    for (int n = 0; n < 160; n++) begin
      r = $urandom_range(0, 99);
      if (r < 85)      d = 4'hF ^ (4'b0001 << $urandom_range(0, 3));
      else if (r < 90) d = 4'hF;
      else             d = 4'hF ^ (4'b0011 << $urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0) seg = gseg($urandom_range(0, 21), 1'($urandom));
      else                           seg = 8'($urandom);
      drive(d, seg, $urandom_range(2, 9));
      drive(4'hF, 8'hFF, $urandom_range(1, 2));
    end
    check("rand_bad", 32'(bad_scan), 32'(m_bad));

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 40) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    check("drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
